// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer. It stalls an SB-type branch until its forwarded operands are valid, then redirects the PC.
// Defining BRANCH_CTRL_PERF_EN adds branch, taken-branch and stall performance counters.
module branch_ctrl #(
    parameter int XLEN    = 32,
    parameter int STALL_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] id_inst,
    input  logic            id_valid,
    input  logic            hold_i,
    input  logic            branch_taken,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic            mem_mem_read,
    output logic            stall_o,
    output logic            bubble_o,
    output logic            pc_sel_o,
    output logic            flush_ifid_o,
`ifdef BRANCH_CTRL_PERF_EN
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     taken_cnt_o,
    output logic [31:0]     stall_cnt_o,
`endif
    output logic            busy_o
);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t               state, state_n;
    logic [STALL_W-1:0]   cnt, cnt_n;
    logic [STALL_W-1:0]   need;
    logic [4:0]           rs1, rs2;
    logic                 is_br, ex_match, mem_match;
    logic                 unused_inst;

    assign is_br       = id_valid && (id_inst[6:0] == 7'b1100011);
    assign rs1         = id_inst[19:15];
    assign rs2         = id_inst[24:20];
    assign unused_inst = ^{id_inst[XLEN-1:25], id_inst[14:7]};
    assign ex_match    = (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    assign mem_match   = (mem_rd != 5'd0) && ((mem_rd == rs1) || (mem_rd == rs2));

    always_comb begin
        need = '0;
        if (ex_mem_read && ex_match)
            need = STALL_W'(2);
        else if ((ex_reg_write && ex_match) || (mem_mem_read && mem_match))
            need = STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The detecting RUN cycle is the first stall cycle, so WAIT covers the remaining need-1 cycles.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!hold_i) begin
            case (state)
                RUN: begin
                    if (is_br && (need != '0)) begin
                        cnt_n = need - STALL_W'(1);
                        if (need > STALL_W'(1))
                            state_n = WAIT;
                    end
                end
                WAIT: begin
                    cnt_n = cnt - STALL_W'(1);
                    if (cnt <= STALL_W'(1)) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_comb begin
        stall_o      = 1'b0;
        bubble_o     = 1'b0;
        pc_sel_o     = 1'b0;
        flush_ifid_o = 1'b0;
        busy_o       = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (is_br) begin
                        if (need != '0) begin
                            stall_o  = 1'b1;
                            bubble_o = 1'b1;
                        end else begin
                            pc_sel_o     = branch_taken;
                            flush_ifid_o = branch_taken;
                        end
                    end
                end
                WAIT: begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    busy_o   = 1'b1;
                end
                default: ;
            endcase
            // A frozen pipeline keeps the stall request but must not redirect or inject bubbles.
            if (hold_i) begin
                bubble_o     = 1'b0;
                pc_sel_o     = 1'b0;
                flush_ifid_o = 1'b0;
            end
        end
    end

`ifdef BRANCH_CTRL_PERF_EN
    logic resolve;
    assign resolve = (state == RUN) && is_br && (need == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_o    <= '0;
            taken_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (!hold_i) begin
            if (resolve)
                br_cnt_o <= br_cnt_o + 32'd1;
            if (resolve && branch_taken)
                taken_cnt_o <= taken_cnt_o + 32'd1;
            if (stall_o)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl; each cycle drives inputs and compares {stall,bubble,pc_sel,flush,busy}.
module tb_branch_ctrl;

    localparam logic [31:0] BEQ = 32'h0020_8463;  // beq x1,x2
    localparam logic [31:0] ADD = 32'h0020_81B3;  // add x3,x1,x2
    localparam logic [31:0] JAL = 32'h0080_00EF;  // jal x1,8

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst;
    logic        id_valid, hold_i, branch_taken;
    logic [4:0]  ex_rd, mem_rd;
    logic        ex_reg_write, ex_mem_read, mem_mem_read;
    logic        stall_o, bubble_o, pc_sel_o, flush_ifid_o, busy_o;
`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] br_cnt_o, taken_cnt_o, stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_ctrl #(.XLEN(32), .STALL_W(2)) dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
        .hold_i(hold_i), .branch_taken(branch_taken),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .stall_o(stall_o), .bubble_o(bubble_o), .pc_sel_o(pc_sel_o),
        .flush_ifid_o(flush_ifid_o),
`ifdef BRANCH_CTRL_PERF_EN
        .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic r, input logic [31:0] inst, input logic vld,
                       input logic tkn, input logic hld,
                       input logic [4:0] erd, input logic erw, input logic emr,
                       input logic [4:0] mrd, input logic mmr, input logic [4:0] exp_o);
        rst = r; id_inst = inst; id_valid = vld; branch_taken = tkn; hold_i = hld;
        ex_rd = erd; ex_reg_write = erw; ex_mem_read = emr; mem_rd = mrd; mem_mem_read = mmr;
        #4;
        chk(tag, {27'd0, stall_o, bubble_o, pc_sel_o, flush_ifid_o, busy_o}, {27'd0, exp_o});
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        //                     rst inst  v  tk hld erd erw emr mrd mmr  {st,bu,pc,fl,by}
        cyc("rst0",            1, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00000);
        cyc("rst1",            1, BEQ,  1, 1, 0,  1, 1, 1,  0, 0, 5'b00000);
        cyc("beq_taken",       0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        cyc("beq_ntaken",      0, BEQ,  1, 0, 0,  0, 0, 0,  0, 0, 5'b00000);
        cyc("non_branch",      0, ADD,  1, 1, 0,  1, 1, 1,  0, 0, 5'b00000);
        cyc("jal_ignored",     0, JAL,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00000);
        cyc("invalid_id",      0, BEQ,  0, 1, 0,  1, 1, 1,  0, 0, 5'b00000);
        // load-use: 2 stall cycles then resolve
        cyc("lu_stall_run",    0, BEQ,  1, 1, 0,  1, 1, 1,  0, 0, 5'b11000);
        cyc("lu_stall_wait",   0, BEQ,  1, 1, 0,  0, 0, 0,  1, 1, 5'b11001);
        cyc("lu_resolve",      0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        // ALU producer in EX: 1 stall cycle
        cyc("alu_stall",       0, BEQ,  1, 1, 0,  2, 1, 0,  0, 0, 5'b11000);
        cyc("alu_resolve_nt",  0, BEQ,  1, 0, 0,  0, 0, 0,  2, 0, 5'b00000);
        cyc("x0_load_nostall", 0, BEQ,  1, 1, 0,  0, 1, 1,  0, 0, 5'b00110);
        cyc("mem_load_stall",  0, BEQ,  1, 1, 0,  0, 0, 0,  2, 1, 5'b11000);
        cyc("mem_load_res",    0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        // hold during WAIT
        cyc("hold_enter",      0, BEQ,  1, 1, 0,  2, 1, 1,  0, 0, 5'b11000);
        cyc("hold_w0",         0, BEQ,  1, 1, 1,  0, 0, 0,  2, 1, 5'b10001);
        cyc("hold_w1",         0, BEQ,  1, 1, 1,  0, 0, 0,  2, 1, 5'b10001);
        cyc("hold_w2",         0, BEQ,  1, 1, 1,  0, 0, 0,  2, 1, 5'b10001);
        cyc("hold_release",    0, BEQ,  1, 1, 0,  0, 0, 0,  2, 1, 5'b11001);
        cyc("hold_resolve",    0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        // hold on the resolve cycle defers the redirect
        cyc("hold_run",        0, BEQ,  1, 1, 1,  0, 0, 0,  0, 0, 5'b00000);
        cyc("hold_run_retry",  0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        // reset pulse in the middle of WAIT
        cyc("rw_enter",        0, BEQ,  1, 1, 0,  1, 1, 1,  0, 0, 5'b11000);
        cyc("rw_rst",          1, BEQ,  1, 1, 0,  0, 0, 0,  1, 1, 5'b00000);
        cyc("rw_after",        0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
`ifdef BRANCH_CTRL_PERF_EN
        cyc("perf_rst",        1, BEQ,  1, 0, 0,  0, 0, 0,  0, 0, 5'b00000);
        chk("perf_br_rst", br_cnt_o, 32'd0);
        chk("perf_tk_rst", taken_cnt_o, 32'd0);
        chk("perf_st_rst", stall_cnt_o, 32'd0);
        cyc("perf_b1",         0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        cyc("perf_b2_s0",      0, BEQ,  1, 1, 0,  1, 1, 1,  0, 0, 5'b11000);
        cyc("perf_b2_s1",      0, BEQ,  1, 1, 0,  0, 0, 0,  1, 1, 5'b11001);
        cyc("perf_b2_res",     0, BEQ,  1, 1, 0,  0, 0, 0,  0, 0, 5'b00110);
        cyc("perf_hold",       0, BEQ,  1, 1, 1,  0, 0, 0,  0, 0, 5'b00000);
        cyc("perf_b3",         0, BEQ,  1, 0, 0,  0, 0, 0,  0, 0, 5'b00000);
        chk("perf_br", br_cnt_o, 32'd3);
        chk("perf_taken", taken_cnt_o, 32'd2);
        chk("perf_stall", stall_cnt_o, 32'd2);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
